// File: rtl/gpo_shift_pkg.sv
// gpo_shift_pkg
// Shared definitions for the GPO serial shift driver.
//   gpo_state_e      : 2-bit FSM encoding (IDLE=0, SHIFT_LO=1, SHIFT_HI=2, LATCH=3)
//   GPO_SHIFT_BITS   : width of the output word shipped per transfer
//   GPO_SHIFT_CNT_W  : width of the bit counter that walks the word
package gpo_shift_pkg;

  localparam int GPO_SHIFT_BITS  = 32;
  localparam int GPO_SHIFT_CNT_W = $clog2(GPO_SHIFT_BITS);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT_LO = 2'd1,
    ST_SHIFT_HI = 2'd2,
    ST_LATCH    = 2'd3
  } gpo_state_e;

endpackage

// File: rtl/gpo_tick_gen.sv
// gpo_tick_gen
// DIV-cycle phase counter. Counts 0..DIV-1 and raises phase_end on the
// last count of each phase. A synchronous clear restarts the phase so the
// first cycle after a clear is count 0.
// Ports:
//   clk       in   system clock
//   reset     in   synchronous active-high reset
//   clear     in   restart the phase on the next edge
//   phase_end out  high on the final cycle of a DIV-cycle phase
module gpo_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic phase_end
);

  // A DIV of 1 still needs a 1-bit counter; it simply never leaves 0.
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign phase_end = (cnt == LAST);

endmodule

// File: rtl/gpo_shift_driver.sv
// gpo_shift_driver
// Ships the 32-bit GPO word MSB-first to an external 74HC595-style chain
// over sclk/sdata/latch. Each bit is a low half-period (data set up) then a
// high half-period (chain samples on the rising edge); after bit 0 a latch
// phase strobes the storage register. Every phase lasts DIV clock cycles,
// so a transfer is 65*DIV cycles.
//
// Requests: start is a level request sampled every cycle. In IDLE a request
// launches a transfer immediately; while busy (including the done cycle) it
// sets a pending flag so any number of requests collapse into one follow-up
// transfer, which launches after one IDLE cycle and ships the word present
// at launch time.
//
// Build option: define GPO_SHIFT_CHANGE_DETECT_EN to also treat
// word != last_sent as a request. Without it last_sent is not built.
//
// Ports:
//   clk, reset  in   system clock, synchronous active-high reset
//   word[31:0]  in   output word, bit 31 shifted first
//   start       in   transfer request
//   sclk        out  serial clock to the chain
//   sdata       out  serial data (0 in IDLE and LATCH)
//   latch       out  storage-register strobe
//   busy        out  transfer in progress
//   done        out  pulse on the last cycle of a transfer
//   dbg_state   out  current FSM state (gpo_state_e encoding)
module gpo_shift_driver
  import gpo_shift_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [GPO_SHIFT_BITS-1:0] word,
  input  logic                      start,
  output logic                      sclk,
  output logic                      sdata,
  output logic                      latch,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                dbg_state
);

  gpo_state_e                 state;
  gpo_state_e                 state_next;
  logic [GPO_SHIFT_BITS-1:0]  shreg;
  logic [GPO_SHIFT_CNT_W-1:0] bitcnt;
  logic                       pending;
  logic                       phase_end;
  logic                       word_changed;
  logic                       req;
  logic                       launch;

`ifdef GPO_SHIFT_CHANGE_DETECT_EN
  logic [GPO_SHIFT_BITS-1:0] last_sent;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_sent <= '0;
    end else if (launch) begin
      last_sent <= word;
    end
  end

  assign word_changed = (word != last_sent);
`else
  assign word_changed = 1'b0;
`endif

  assign req    = start | word_changed;
  assign launch = (state == ST_IDLE) && (req || pending);

  // Restarting the phase counter on every state change makes each state
  // last exactly DIV cycles regardless of where the free-running count was.
  gpo_tick_gen #(.DIV(DIV)) u_tick (
    .clk       (clk),
    .reset     (reset),
    .clear     (state_next != state),
    .phase_end (phase_end)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (launch)    state_next = ST_SHIFT_LO;
      ST_SHIFT_LO: if (phase_end) state_next = ST_SHIFT_HI;
      ST_SHIFT_HI: if (phase_end) state_next = (bitcnt == '0) ? ST_LATCH : ST_SHIFT_LO;
      ST_LATCH:    if (phase_end) state_next = ST_IDLE;
      default:                    state_next = ST_IDLE;
    endcase
  end

  // Outputs decode the registered state and shift register only, so no
  // input reaches a pin combinationally.
  always_comb begin
    sclk  = 1'b0;
    sdata = 1'b0;
    latch = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      ST_SHIFT_LO: begin
        busy  = 1'b1;
        sdata = shreg[GPO_SHIFT_BITS-1];
      end
      ST_SHIFT_HI: begin
        busy  = 1'b1;
        sclk  = 1'b1;
        sdata = shreg[GPO_SHIFT_BITS-1];
      end
      ST_LATCH: begin
        busy  = 1'b1;
        latch = 1'b1;
        done  = phase_end;
      end
      default: ;
    endcase
  end

  assign dbg_state = state;

  // Datapath: word capture, bit walk and request coalescing.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg   <= '0;
      bitcnt  <= '0;
      pending <= 1'b0;
    end else if (launch) begin
      shreg   <= word;
      bitcnt  <= GPO_SHIFT_CNT_W'(GPO_SHIFT_BITS - 1);
      pending <= 1'b0;
    end else begin
      if ((state != ST_IDLE) && req) begin
        pending <= 1'b1;
      end
      // Advance to the next bit at the end of a high phase, except after
      // bit 0 where the FSM moves on to LATCH instead.
      if ((state == ST_SHIFT_HI) && phase_end && (bitcnt != '0)) begin
        shreg  <= shreg << 1;
        bitcnt <= bitcnt - 1'b1;
      end
    end
  end

endmodule
